// File: rtl/crc_stream_engine.sv
// Sequential CRC engine: folds one byte lane per clock from a strobed word
// stream and emits the finalised CRC on the frame's last beat.
module crc_stream_engine #(
  parameter int unsigned CRC_WIDTH  = 32,
  parameter logic [63:0] POLY       = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] INIT       = 64'h0000_0000_FFFF_FFFF,
  parameter logic [63:0] XOROUT     = 64'h0000_0000_FFFF_FFFF,
  parameter bit          REFIN      = 1'b1,
  parameter bit          REFOUT     = 1'b1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic                    last_i,
  output logic [CRC_WIDTH-1:0]    crc_o,
  output logic                    crc_valid_o,
  output logic                    busy_o
);

  localparam int unsigned NLANES = DATA_WIDTH / 8;
  localparam int unsigned LW     = (NLANES > 1) ? $clog2(NLANES) : 1;

  localparam logic [CRC_WIDTH-1:0] POLY_T   = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT_T   = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XOROUT_T = XOROUT[CRC_WIDTH-1:0];
  localparam logic [LW-1:0]        LANE_LAST = LW'(NLANES - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state, state_nxt;
  logic [CRC_WIDTH-1:0]  crc_state, crc_nxt, crc_fold;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NLANES-1:0]     strb_q;
  logic                  last_q;
  logic [LW-1:0]         lane_q;
  logic [7:0]            lane_byte;
  logic                  fin_en;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bitrev_w(input logic [CRC_WIDTH-1:0] s);
    logic [CRC_WIDTH-1:0] r;
    for (int unsigned i = 0; i < CRC_WIDTH; i++) r[i] = s[CRC_WIDTH-1-i];
    return r;
  endfunction

  // MSB-first byte fold: align the byte under the top of the state, then shift 8 times
  function automatic logic [CRC_WIDTH-1:0] fold_byte(input logic [CRC_WIDTH-1:0] s_in,
                                                     input logic [7:0] b);
    logic [CRC_WIDTH-1:0] s;
    logic [CRC_WIDTH-1:0] bx;
    bx = '0;
    bx[CRC_WIDTH-1 -: 8] = b;
    s = s_in ^ bx;
    for (int unsigned i = 0; i < 8; i++)
      s = s[CRC_WIDTH-1] ? ((s << 1) ^ POLY_T) : (s << 1);
    return s;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] finalise(input logic [CRC_WIDTH-1:0] s);
    return (REFOUT ? bitrev_w(s) : s) ^ XOROUT_T;
  endfunction

  // ready is also held low while reset is asserted, even once the state has settled to IDLE
  assign ready_o = (state == IDLE) && !rst_i;
  assign busy_o  = (state == CALC);

  // next-state, running-CRC update and finalise strobe
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_state;
    fin_en    = 1'b0;
    lane_byte = data_q[8*lane_q +: 8];
    crc_fold  = crc_state;
    if (strb_q[lane_q])
      crc_fold = fold_byte(crc_state, REFIN ? bitrev8(lane_byte) : lane_byte);
    case (state)
      IDLE: begin
        if (clr_i)   crc_nxt   = INIT_T;
        if (valid_i) state_nxt = CALC;
      end
      CALC: begin
        crc_nxt = crc_fold;
        if (lane_q == LANE_LAST) begin
          state_nxt = IDLE;
          if (last_q) begin
            crc_nxt = INIT_T;
            fin_en  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // datapath: running state, latched beat, lane counter and registered result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_state   <= INIT_T;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      last_q      <= 1'b0;
      lane_q      <= '0;
    end else begin
      crc_state   <= crc_nxt;
      crc_valid_o <= fin_en;
      if (fin_en) crc_o <= finalise(crc_fold);
      if (state == IDLE && valid_i) begin
        data_q <= data_i;
        strb_q <= strb_i;
        last_q <= last_i;
        lane_q <= '0;
      end else if (state == CALC) begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: five byte-wide variants share one input
// bus, one 32-bit-wide default instance has its own bus.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // byte-wide shared bus
  logic       clr8, valid8, last8;
  logic [7:0] data8;
  logic [0:0] strb8;
  logic        rdy_d, rdy_m, rdy_b, rdy_16, rdy_c;
  logic        bsy_d, bsy_m, bsy_b, bsy_16, bsy_c;
  logic        vld_d, vld_m, vld_b, vld_16, vld_c;
  logic [31:0] crc_d, crc_m, crc_b;
  logic [15:0] crc_16;
  logic [7:0]  crc_c;

  // 32-bit bus
  logic        clr32, valid32, last32, rdy32, bsy32, vld32;
  logic [31:0] data32, crc32w;
  logic [3:0]  strb32;

  crc_stream_engine #(.DATA_WIDTH(8)) u_def8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8), .valid_i(valid8), .ready_o(rdy_d),
    .data_i(data8), .strb_i(strb8), .last_i(last8), .crc_o(crc_d),
    .crc_valid_o(vld_d), .busy_o(bsy_d));

  crc_stream_engine #(.DATA_WIDTH(8), .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(64'h0)) u_mpeg (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8), .valid_i(valid8), .ready_o(rdy_m),
    .data_i(data8), .strb_i(strb8), .last_i(last8), .crc_o(crc_m),
    .crc_valid_o(vld_m), .busy_o(bsy_m));

  crc_stream_engine #(.DATA_WIDTH(8), .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(64'hFFFF_FFFF)) u_bzip (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8), .valid_i(valid8), .ready_o(rdy_b),
    .data_i(data8), .strb_i(strb8), .last_i(last8), .crc_o(crc_b),
    .crc_valid_o(vld_b), .busy_o(bsy_b));

  crc_stream_engine #(.CRC_WIDTH(16), .POLY(64'h1021), .INIT(64'hFFFF), .XOROUT(64'h0),
                      .REFIN(1'b0), .REFOUT(1'b0), .DATA_WIDTH(8)) u_c16 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8), .valid_i(valid8), .ready_o(rdy_16),
    .data_i(data8), .strb_i(strb8), .last_i(last8), .crc_o(crc_16),
    .crc_valid_o(vld_16), .busy_o(bsy_16));

  crc_stream_engine #(.CRC_WIDTH(8), .POLY(64'h07), .INIT(64'h0), .XOROUT(64'h0),
                      .REFIN(1'b0), .REFOUT(1'b0), .DATA_WIDTH(8)) u_c8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr8), .valid_i(valid8), .ready_o(rdy_c),
    .data_i(data8), .strb_i(strb8), .last_i(last8), .crc_o(crc_c),
    .crc_valid_o(vld_c), .busy_o(bsy_c));

  crc_stream_engine #(.DATA_WIDTH(32)) u_def32 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr32), .valid_i(valid32), .ready_o(rdy32),
    .data_i(data32), .strb_i(strb32), .last_i(last32), .crc_o(crc32w),
    .crc_valid_o(vld32), .busy_o(bsy32));

  typedef struct {
    logic [31:0] e32;
    logic [31:0] em;
    logic [31:0] eb;
    logic [15:0] e16;
    logic [7:0]  e8;
  } crcset_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        clr;
    logic        exp_valid;
    crcset_t     exp;
  } vec_t;

  vec_t    t8[$];
  vec_t    t32[$];
  crcset_t cr_res, cr_empty, cr_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses8  = 0;
  int pulses32 = 0;
  int exp_p8   = 0;
  int exp_p32  = 0;

  // count result pulses; a pulse is high for one full cycle so each is seen once
  always @(posedge clk) begin
    if (vld_d)  pulses8++;
    if (vld32)  pulses32++;
  end

  function automatic vec_t mk(input logic [31:0] d, input logic [3:0] s, input logic l,
                              input logic c, input logic ev, input crcset_t e);
    vec_t v;
    v.data = d; v.strb = s; v.last = l; v.clr = c; v.exp_valid = ev; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Present one beat ahead of the next edge, hold junk (with clr) on the bus
  // during CALC, and return how many sampled cycles ready stayed low.
  task automatic send(input bit wide, input vec_t v, output int lowcyc);
    if (wide) begin
      data32 = v.data; strb32 = v.strb; last32 = v.last; clr32 = v.clr; valid32 = 1'b1;
    end else begin
      data8 = v.data[7:0]; strb8 = v.strb[0]; last8 = v.last; clr8 = v.clr; valid8 = 1'b1;
    end
    @(posedge clk); #1;
    if (wide) begin
      data32 = $urandom; strb32 = 4'($urandom); last32 = 1'b1; clr32 = 1'b1;
    end else begin
      data8 = 8'($urandom); strb8 = 1'b1; last8 = 1'b1; clr8 = 1'b1;
    end
    lowcyc = 0;
    while (!(wide ? rdy32 : rdy_d) && lowcyc < 20) begin
      @(posedge clk); #1;
      lowcyc++;
    end
    valid8 = 1'b0; clr8 = 1'b0; valid32 = 1'b0; clr32 = 1'b0;
  endtask

  task automatic run32(input int first, input int count);
    int lc;
    for (int i = first; i < first + count; i++) begin
      send(1'b1, t32[i], lc);
      check($sformatf("w32[%0d] ready_low_cycles", i), 64'(lc), 64'd4);
      check($sformatf("w32[%0d] crc_valid", i), 64'(vld32), 64'(t32[i].exp_valid));
      check($sformatf("w32[%0d] crc", i), 64'(crc32w), 64'(t32[i].exp.e32));
      check($sformatf("w32[%0d] busy", i), 64'(bsy32), 64'd0);
      if (t32[i].exp_valid) exp_p32++;
    end
  endtask

  initial begin
    int lc;
    rst = 1'b1;
    clr8 = 0; valid8 = 0; last8 = 0; data8 = '0; strb8 = '0;
    clr32 = 0; valid32 = 0; last32 = 0; data32 = '0; strb32 = '0;

    cr_res   = '{32'hCBF4_3926, 32'h0376_E6E7, 32'hFC89_1918, 16'h29B1, 8'hF4};
    cr_empty = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 16'hFFFF, 8'h00};
    cr_zero  = '{32'h0, 32'h0, 32'h0, 16'h0, 8'h0};

    // frame "123456789"
    for (int k = 0; k < 9; k++)
      t8.push_back(mk(32'h31 + 32'(k), 4'h1, k == 8, 1'b0, k == 8, (k == 8) ? cr_res : cr_zero));
    // empty frame: single last beat with strobe low
    t8.push_back(mk(32'hA5, 4'h0, 1'b1, 1'b0, 1'b1, cr_empty));
    // same frame with a skipped lane in the middle
    for (int k = 0; k < 9; k++) begin
      if (k == 4) t8.push_back(mk(32'hC3, 4'h0, 1'b0, 1'b0, 1'b0, cr_empty));
      t8.push_back(mk(32'h31 + 32'(k), 4'h1, k == 8, 1'b0, k == 8, (k == 8) ? cr_res : cr_empty));
    end
    // junk bytes, then clear together with the first real byte
    t8.push_back(mk(32'hAB, 4'h1, 1'b0, 1'b0, 1'b0, cr_res));
    t8.push_back(mk(32'hCD, 4'h1, 1'b0, 1'b0, 1'b0, cr_res));
    for (int k = 0; k < 9; k++)
      t8.push_back(mk(32'h31 + 32'(k), 4'h1, k == 8, k == 0, k == 8, cr_res));

    t32.push_back(mk(32'h3433_3231, 4'hF, 1'b0, 1'b0, 1'b0, cr_zero));
    t32.push_back(mk(32'h3837_3635, 4'hF, 1'b0, 1'b0, 1'b0, cr_zero));
    t32.push_back(mk(32'h0000_0039, 4'h1, 1'b1, 1'b0, 1'b1, cr_res));
    t32.push_back(mk(32'hDEAD_BEEF, 4'h0, 1'b1, 1'b0, 1'b1, cr_empty));
    t32.push_back(mk(32'h3433_3231, 4'hF, 1'b0, 1'b0, 1'b0, cr_empty));
    t32.push_back(mk(32'h36EE_35EE, 4'hA, 1'b0, 1'b0, 1'b0, cr_empty));
    t32.push_back(mk(32'h3938_37AA, 4'hE, 1'b1, 1'b0, 1'b1, cr_res));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset8", 64'(rdy_d), 64'd0);
    check("ready_in_reset32", 64'(rdy32), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'({rdy_d, rdy_m, rdy_b, rdy_16, rdy_c, rdy32}), 64'h3F);
    check("busy_after_reset", 64'({bsy_d, bsy_m, bsy_b, bsy_16, bsy_c, bsy32}), 64'h0);
    check("crc_valid_after_reset", 64'({vld_d, vld_m, vld_b, vld_16, vld_c, vld32}), 64'h0);
    check("crc_after_reset", 64'(crc_d | crc32w), 64'h0);

    // byte-wide table
    for (int i = 0; i < t8.size(); i++) begin
      send(1'b0, t8[i], lc);
      check($sformatf("b8[%0d] ready_low_cycles", i), 64'(lc), 64'd1);
      check($sformatf("b8[%0d] crc_valid", i),
            64'({vld_d, vld_m, vld_b, vld_16, vld_c}), t8[i].exp_valid ? 64'h1F : 64'h0);
      check($sformatf("b8[%0d] crc32", i), 64'(crc_d), 64'(t8[i].exp.e32));
      check($sformatf("b8[%0d] mpeg2", i), 64'(crc_m), 64'(t8[i].exp.em));
      check($sformatf("b8[%0d] bzip2", i), 64'(crc_b), 64'(t8[i].exp.eb));
      check($sformatf("b8[%0d] crc16", i), 64'(crc_16), 64'(t8[i].exp.e16));
      check($sformatf("b8[%0d] crc8", i), 64'(crc_c), 64'(t8[i].exp.e8));
      check($sformatf("b8[%0d] idle", i),
            64'({rdy_m, rdy_b, rdy_16, rdy_c, bsy_d, bsy_m, bsy_b, bsy_16, bsy_c}), 64'h1E0);
      if (t8[i].exp_valid) exp_p8++;
    end

    // 32-bit table
    run32(0, t32.size());

    // reset in the middle of a last word's CALC
    data32 = 32'h3433_3231; strb32 = 4'hF; last32 = 1'b1; valid32 = 1'b1;
    @(posedge clk); #1;
    valid32 = 1'b0;
    check("rst_mid busy_before", 64'(bsy32), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid ready_with_rst", 64'(rdy32), 64'd0);
    @(posedge clk); #1;
    check("rst_mid ready_held_low", 64'(rdy32), 64'd0);
    check("rst_mid busy", 64'(bsy32), 64'd0);
    check("rst_mid crc", 64'(crc32w), 64'd0);
    check("rst_mid crc8lane", 64'(crc_d), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_mid ready_after", 64'(rdy32), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid no_pulse", 64'(pulses32), 64'(exp_p32));
    check("rst_mid crc_held", 64'(crc32w), 64'd0);

    // full frame after the aborted one
    run32(0, 3);

    repeat (3) @(posedge clk);
    #1;
    check("pulse_count8", 64'(pulses8), 64'(exp_p8));
    check("pulse_count32", 64'(pulses32), 64'(exp_p32));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
